// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
// Groups the signals between the UART receiver/consumer side and the receive
// byte FIFO.
//   master : drives rx_data, rx_done, rd_en, flush, clr_overrun;
//            observes rd_data, empty, full, count, overrun
//   slave  : the FIFO itself (the mirror image of master)
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if #(
    parameter int AW = 4
);
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        rd_en;
    logic        flush;
    logic        clr_overrun;
    logic [7:0]  rd_data;
    logic        empty;
    logic        full;
    logic [AW:0] count;
    logic        overrun;

    modport master (
        output rx_data, rx_done, rd_en, flush, clr_overrun,
        input  rd_data, empty, full, count, overrun
    );

    modport slave (
        input  rx_data, rx_done, rd_en, flush, clr_overrun,
        output rd_data, empty, full, count, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Byte FIFO between the UART receiver and the bootloader (same clock).
// Each rising edge of rx_done captures rx_data; the consumer pops with rd_en.
// The head byte is presented first-word-fall-through on rd_data.
// Ports:
//   clk  : system clock
//   rst  : asynchronous reset, active-high
//   bus  : uart_rx_fifo_if.slave
//          in  rx_data[7:0], rx_done, rd_en, flush, clr_overrun
//          out rd_data[7:0], empty, full, count[AW:0], overrun (sticky)
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic            clk,
    input  logic            rst,
    uart_rx_fifo_if.slave   bus
);
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [7:0]    mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          overrun_q, overrun_d;
    logic          rx_done_q;

    logic          is_empty;
    logic          is_full;
    logic          wr_evt;
    logic          wr_acc;
    logic          rd_acc;
    logic          drop;

    always_comb begin
        is_empty  = (count_q == '0);
        is_full   = (count_q == CNT_FULL);
        // One write per strobe: only the low-to-high transition counts.
        wr_evt    = bus.rx_done & ~rx_done_q;
        // A flush discards any same-cycle read or write.
        rd_acc    = bus.rd_en & ~is_empty & ~bus.flush;
        // When full, a same-cycle pop frees the slot the write needs.
        wr_acc    = wr_evt & (~is_full | rd_acc) & ~bus.flush;
        drop      = wr_evt & is_full & ~rd_acc & ~bus.flush;

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end

        // Setting wins over a same-cycle clear so no drop goes unreported.
        if (drop) begin
            overrun_d = 1'b1;
        end else if (bus.clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            rx_done_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            rx_done_q <= bus.rx_done;
        end
    end

    // Storage is deliberately not reset; only the pointers define contents.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= bus.rx_data;
        end
    end

    assign bus.rd_data = mem[rd_ptr_q];
    assign bus.empty   = is_empty;
    assign bus.full    = is_full;
    assign bus.count   = count_q;
    assign bus.overrun = overrun_q;

endmodule
